// File: rtl/sll32_seq.sv
// sll32_seq: multi-cycle logical left shifter with a start/done handshake.
// The shift amount is taken either from the sll instruction field A[10:6]
// or from the sllv register bits A[4:0]. The operand is shifted by at most
// STEP positions per cycle. While the shift runs, busy lets the ALU stall
// instead of needing a full barrel shifter.
module sll32_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        var_sh,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The count is 6 bits wide, so STEP=32 fits and cnt - STEP never wraps.
    localparam logic [5:0] STEP_C = 6'(STEP);

    state_t      state_r;
    logic [31:0] acc_r;
    logic [31:0] res_r;
    logic [5:0]  cnt_r;
    logic        busy_r;
    logic        done_r;

    logic [5:0]  shamt_s;
    logic [31:0] acc_step_s;
    logic [31:0] acc_last_s;
    logic        unused_a_s;

    // These bits of A carry neither encoding of the shift amount.
    assign unused_a_s = ^{A[31:11], A[5]};

    // Select the shift amount: register form (sllv) or immediate field (sll).
    always_comb begin
        shamt_s = 6'd0;
        if (var_sh) begin
            shamt_s = {1'b0, A[4:0]};
        end else begin
            shamt_s = {1'b0, A[10:6]};
        end
    end

    // Candidate next accumulators: a full STEP, or the final partial chunk.
    always_comb begin
        acc_step_s = 32'd0;
        acc_last_s = 32'd0;
        acc_step_s = acc_r << STEP_C;
        acc_last_s = acc_r << cnt_r;
    end

    // Control FSM with datapath registers. busy and done are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= 32'd0;
            res_r   <= 32'd0;
            cnt_r   <= 6'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        acc_r   <= B;
                        cnt_r   <= shamt_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    busy_r <= 1'b1;
                    if (cnt_r <= STEP_C) begin
                        // Last chunk. A zero count lands here too, so res = B.
                        acc_r   <= acc_last_s;
                        res_r   <= acc_last_s;
                        cnt_r   <= 6'd0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        acc_r   <= acc_step_s;
                        cnt_r   <= cnt_r - STEP_C;
                        done_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // The done pulse lasts one cycle. Any start seen here is dropped.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign res  = res_r;

endmodule

// File: tb/tb_sll32_seq.sv
// Bench for sll32_seq. Several instances with different STEP values share
// the same stimulus. A transaction-level model predicts busy, done and res
// for every instance on every cycle. Directed cases also pin literal values.
module tb_sll32_seq;

    localparam int NI = 5;

    function automatic int step_of(int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 32;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        var_sh = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;

    logic        busy_w [NI];
    logic        done_w [NI];
    logic [31:0] res_w  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sll32_seq #(.STEP(step_of(g))) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start),
            .var_sh (var_sh),
            .A      (A),
            .B      (B),
            .busy   (busy_w[g]),
            .done   (done_w[g]),
            .res    (res_w[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Number of edges after the start edge until done is high.
    function automatic int lat(int sh, int st);
        int n;
        n = (sh + st - 1) / st;
        return (n < 1) ? 1 : n;
    endfunction

    // Model state per instance. left = cycles until the instance is idle
    // again: 0 = idle, 1 = done cycle.
    int          m_left [NI];
    logic [31:0] m_res  [NI];
    logic [31:0] m_pend [NI];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: accept start when idle, deliver B<<shamt after lat() edges.
    always @(posedge clk or negedge rst_n) begin
        int sh;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_left[i] = 0;
                m_res[i]  = 32'd0;
                m_pend[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_left[i] == 0) begin
                    if (start) begin
                        sh = var_sh ? int'(A[4:0]) : int'(A[10:6]);
                        m_pend[i] = B << sh;
                        m_left[i] = lat(sh, step_of(i)) + 1;
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 1) m_res[i] = m_pend[i];
                end
            end
        end
    end

    // Compare every instance with the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("busy[%0d]", i), {31'd0, busy_w[i]}, {31'd0, (m_left[i] > 0)});
                chk($sformatf("done[%0d]", i), {31'd0, done_w[i]}, {31'd0, (m_left[i] == 1)});
                chk($sformatf("res[%0d]", i), res_w[i], m_res[i]);
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = 1'b1;
            for (int i = 0; i < NI; i++) if (busy_w[i] !== 1'b0) ok = 1'b0;
            if (ok) break;
        end
        if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    // Drive start for one cycle, then change the inputs to check they were captured.
    task automatic issue(input logic vs, input logic [31:0] a, input logic [31:0] b, output int s);
        @(negedge clk);
        start = 1'b1; var_sh = vs; A = a; B = b;
        s = cyc;
        @(negedge clk);
        start = 1'b0; var_sh = 1'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(input int k, input int s, input int exp_n,
                             input logic [31:0] exp_res, input string name);
        bit found;
        found = 1'b0;
        if (done_w[k] === 1'b1) found = 1'b1;
        for (int j = 0; j < 100 && !found; j++) begin
            @(negedge clk);
            if (done_w[k] === 1'b1) found = 1'b1;
        end
        if (!found) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(cyc - s - 1), 32'(exp_n));
            chk({name, "_res"}, res_w[k], exp_res);
        end
    endtask

    initial begin
        int s;
        int cnt;
        int dn;
        #12;
        for (int i = 0; i < NI; i++) begin
            chk("reset_busy", {31'd0, busy_w[i]}, 32'd0);
            chk("reset_done", {31'd0, done_w[i]}, 32'd0);
            chk("reset_res", res_w[i], 32'd0);
        end
        #10 rst_n = 1'b1;

        // Case 1: STEP=1, shamt=31 from A[10:6], B=1.
        wait_idle();
        issue(1'b0, 32'd31 << 6, 32'd1, s);
        wait_done(0, s, 31, 32'h8000_0000, "t1");
        chk("t1_busy_in_done", {31'd0, busy_w[0]}, 32'd1);
        @(negedge clk);
        chk("t1_busy_after", {31'd0, busy_w[0]}, 32'd0);

        // Case 2: STEP=8, shamt=20 from A[4:0].
        wait_idle();
        issue(1'b1, 32'd20, 32'h0000_0ABC, s);
        wait_done(3, s, 3, 32'hABC0_0000, "t2");

        // Case 3: STEP=4, shamt=0.
        wait_idle();
        issue(1'b1, 32'h0000_0FE0, 32'hDEAD_BEEF, s);
        wait_done(2, s, 1, 32'hDEAD_BEEF, "t3");

        // Case 4: STEP=1, shamt=8, start and new B pulsed during the shift.
        wait_idle();
        issue(1'b0, 32'd8 << 6, 32'h0000_00FF, s);
        cnt = 0; dn = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) begin
                cnt++;
                dn = cyc - s - 1;
                chk("t4_res", res_w[0], 32'h0000_FF00);
            end
            if (k == 2) begin
                start = 1'b1; B = 32'hFFFF_FFFF; A = 32'd8 << 6; var_sh = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        chk("t4_done_pulses", 32'(cnt), 32'd1);
        chk("t4_latency", 32'(dn), 32'd8);

        // Case 5: STEP=2, shamt=10, reset pulse during the shift.
        wait_idle();
        issue(1'b0, 32'd10 << 6, 32'h0000_1234, s);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_res_after_rst", res_w[1], 32'd0);
        chk("t5_busy_after_rst", {31'd0, busy_w[1]}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_w[1] === 1'b1) cnt++;
        end
        chk("t5_no_done", 32'(cnt), 32'd0);
        issue(1'b0, 32'd10 << 6, 32'h0000_0003, s);
        wait_done(1, s, 5, 32'h0000_0C00, "t5");

        // Case 6: start held high with random operands. STEP=32 runs back to back.
        wait_idle();
        cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = 1'b1; var_sh = 1'($urandom); A = $urandom; B = $urandom;
            if (done_w[4] === 1'b1) cnt++;
        end
        chk("t6_ops_ge_999", {31'd0, (cnt >= 999)}, 32'd1);

        // Random start pattern as well.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); var_sh = 1'($urandom); A = $urandom; B = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
